// File: rtl/rom_loader_if.sv
// rtl/rom_loader_if.sv - host byte stream and ROM write port bundle for rom_loader
interface rom_loader_if #(
    parameter int ADDR_W = 16
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        input  rx_data, rx_valid,
        output rx_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output rx_data, rx_valid,
        input  rx_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - rk16 instruction ROM loader; trailing checksum byte enabled by ROM_LOADER_CSUM_EN
module rom_loader #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    rom_loader_if.master      bus,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LEN_LO = 3'd1;
    localparam logic [2:0] LEN_HI = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] WRITE  = 3'd4;
    localparam logic [2:0] FIN    = 3'd6;
`ifdef ROM_LOADER_CSUM_EN
    localparam logic [2:0] CSUM   = 3'd5;
    localparam logic [2:0] TAIL   = CSUM;
`else
    localparam logic [2:0] TAIL   = FIN;
`endif

    logic [2:0]        state, state_next;
    logic [ADDR_W-1:0] addr_cnt;
    logic [15:0]       remaining;
    logic [7:0]        len_lo;
    logic [1:0]        byte_idx;
    logic [23:0]       word_sr;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;
    logic              hold_q;
    logic              xfer;

    assign xfer = bus.rx_valid && bus.rx_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = LEN_LO;
            LEN_LO:  if (xfer) state_next = LEN_HI;
            LEN_HI:  if (xfer) state_next = ({bus.rx_data, len_lo} == 16'd0) ? TAIL : DATA;
            DATA:    if (xfer && byte_idx == 2'd3) state_next = WRITE;
            WRITE:   state_next = (remaining == 16'd1) ? TAIL : DATA;
`ifdef ROM_LOADER_CSUM_EN
            CSUM:    if (xfer) state_next = FIN;
`endif
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            remaining <= '0;
            len_lo    <= '0;
            byte_idx  <= '0;
            word_sr   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            hold_q    <= 1'b0;
        end else begin
            state  <= state_next;
            // Tracks the next state so the hold rises with busy and falls right after FIN.
            hold_q <= (state_next != IDLE);
            case (state)
                IDLE: if (start) begin
                    addr_cnt <= base_addr;
                    byte_idx <= 2'd0;
                end
                LEN_LO: if (xfer) len_lo <= bus.rx_data;
                LEN_HI: if (xfer) remaining <= {bus.rx_data, len_lo};
                DATA: if (xfer) begin
                    byte_idx <= byte_idx + 2'd1;
                    word_sr  <= {bus.rx_data, word_sr[23:8]};
                    if (byte_idx == 2'd3) begin
                        wr_data_q <= {bus.rx_data, word_sr};
                        wr_addr_q <= addr_cnt;
                    end
                end
                WRITE: begin
                    addr_cnt  <= addr_cnt + 1'b1;
                    remaining <= remaining - 16'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef ROM_LOADER_CSUM_EN
    logic [7:0] csum;
    logic       err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum  <= '0;
            err_q <= 1'b0;
        end else if (state == IDLE && start) begin
            csum  <= '0;
            err_q <= 1'b0;
        end else if (state == DATA && xfer) begin
            csum <= csum ^ bus.rx_data;
        end else if (state == CSUM && xfer && bus.rx_data != csum) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
    assign bus.rx_ready = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CSUM);
`else
    assign err = 1'b0;
    assign bus.rx_ready = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
`endif

    assign bus.wr_en   = (state == WRITE);
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign busy        = (state != IDLE);
    assign done        = (state == FIN);
    assign cpu_hold    = hold_q;
endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - directed self-checking bench for rom_loader
module tb_rom_loader;
    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic        cpu_hold, busy, done, err;

    rom_loader_if #(.ADDR_W(16)) bus ();

    rom_loader #(.ADDR_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .bus       (bus),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int done_cnt = 0;
    int viol = 0;
    int wbase;
    int d0;
    logic err_at_done;
    logic [15:0] wa_q[$];
    logic [31:0] wd_q[$];

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            wa_q.push_back(bus.wr_addr);
            wd_q.push_back(bus.wr_data);
            if (bus.rx_ready !== 1'b0) viol++;
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_wr(input int k, input logic [15:0] a, input logic [31:0] d);
        if (wbase + k < wa_q.size()) begin
            check("wr_addr", {16'd0, wa_q[wbase+k]}, {16'd0, a});
            check("wr_data", wd_q[wbase+k], d);
        end else begin
            check("wr_missing", 32'd0, 32'd1);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rx_ready"}, {31'd0, bus.rx_ready}, 0);
        check({tag, "_wr_en"},    {31'd0, bus.wr_en}, 0);
        check({tag, "_wr_addr"},  {16'd0, bus.wr_addr}, 0);
        check({tag, "_wr_data"},  bus.wr_data, 0);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 0);
        check({tag, "_busy"},     {31'd0, busy}, 0);
        check({tag, "_done"},     {31'd0, done}, 0);
        check({tag, "_err"},      {31'd0, err}, 0);
    endtask

    task automatic do_start(input logic [15:0] base);
        start = 1'b1;
        base_addr = base;
        @(negedge clk);
        start = 1'b0;
        check("start_busy",     {31'd0, busy}, 1);
        check("start_cpu_hold", {31'd0, cpu_hold}, 1);
        check("start_rx_ready", {31'd0, bus.rx_ready}, 1);
        check("start_err_clr",  {31'd0, err}, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n = 0;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data = b;
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("rx_timeout", 32'(n), 0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {31'd0, n < 200}, 1);
        err_at_done = err;
        check("hold_at_done", {31'd0, cpu_hold}, 1);
        @(negedge clk);
        check("hold_after_done", {31'd0, cpu_hold}, 0);
        check("busy_after_done", {31'd0, busy}, 0);
        check("done_one_cycle",  {31'd0, done}, 0);
    endtask

    task automatic load_words(input logic [15:0] base, input logic [15:0] n,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input bit gaps, input bit bad, input bit poke);
        logic [7:0]  cs;
        logic [31:0] w;
        cs = 8'd0;
        wbase = wa_q.size();
        d0 = done_cnt;
        do_start(base);
        send_byte(n[7:0], gaps);
        send_byte(n[15:8], gaps);
        for (int i = 0; i < int'(n); i++) begin
            w = (i == 0) ? w0 : w1;
            for (int j = 0; j < 4; j++) begin
                send_byte(w[8*j +: 8], gaps);
                cs = cs ^ w[8*j +: 8];
                if (poke && i == 0 && j == 1) begin
                    start = 1'b1;
                    base_addr = 16'h0099;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
        end
        cs = cs ^ {7'd0, bad};
`ifdef ROM_LOADER_CSUM_EN
        send_byte(cs, gaps);
`endif
        wait_done();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base_addr = 16'd0;
        bus.rx_data = 8'd0;
        bus.rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // Abort mid-word, then a clean single-word load
        wbase = wa_q.size();
        do_start(16'h0020);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h78, 1'b0);
        send_byte(8'h56, 1'b0);
        rst = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_no_write", 32'(wa_q.size() - wbase), 0);
        load_words(16'h0020, 16'd1, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0);
        check("one_word_count", 32'(wa_q.size() - wbase), 1);
        check_wr(0, 16'h0020, 32'h12345678);

        // Basic two-word load at full rate
        load_words(16'h0010, 16'd2, 32'h00000013, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        check("basic_count", 32'(wa_q.size() - wbase), 2);
        check_wr(0, 16'h0010, 32'h00000013);
        check_wr(1, 16'h0011, 32'hDEADBEEF);
        check("basic_done_once", 32'(done_cnt - d0), 1);

        // Same stream with random valid gaps
        load_words(16'h0010, 16'd2, 32'h00000013, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
        check("gap_count", 32'(wa_q.size() - wbase), 2);
        check_wr(0, 16'h0010, 32'h00000013);
        check_wr(1, 16'h0011, 32'hDEADBEEF);

        // Address wrap
        load_words(16'hFFFF, 16'd2, 32'hA5A5_0001, 32'h5A5A_0002, 1'b0, 1'b0, 1'b0);
        check("wrap_count", 32'(wa_q.size() - wbase), 2);
        check_wr(0, 16'hFFFF, 32'hA5A5_0001);
        check_wr(1, 16'h0000, 32'h5A5A_0002);

        // Zero-length load
        load_words(16'h0060, 16'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("zero_no_write", 32'(wa_q.size() - wbase), 0);
        check("zero_done_once", 32'(done_cnt - d0), 1);
        check("zero_err", {31'd0, err_at_done}, 0);
        check("zero_wr_hold", {16'd0, bus.wr_addr}, 32'h0000);

        // Start during DATA must be ignored
        load_words(16'h0030, 16'd2, 32'h11223344, 32'h55667788, 1'b0, 1'b0, 1'b1);
        check("poke_count", 32'(wa_q.size() - wbase), 2);
        check_wr(0, 16'h0030, 32'h11223344);
        check_wr(1, 16'h0031, 32'h55667788);

`ifdef ROM_LOADER_CSUM_EN
        load_words(16'h0040, 16'd1, 32'h04030201, 32'h0, 1'b0, 1'b0, 1'b0);
        check("csum_good_err", {31'd0, err_at_done}, 0);
        load_words(16'h0040, 16'd1, 32'h04030201, 32'h0, 1'b0, 1'b1, 1'b0);
        check("csum_bad_err", {31'd0, err_at_done}, 1);
        repeat (3) @(negedge clk);
        check("csum_err_sticky", {31'd0, err}, 1);
        do_start(16'h0050);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        wait_done();
        check("csum_zero_err", {31'd0, err_at_done}, 0);
`endif

        check("no_ready_in_write", 32'(viol), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
